// File: rtl/mux8_rr_scheduler_pkg.sv
// Shared types and constants for the 8-lane round-robin output scheduler.
package mux8_rr_scheduler_pkg;

  localparam int unsigned NumLanes = 8;
  localparam int unsigned SelW     = 3;

  typedef enum logic {
    StIdle,
    StGrant
  } state_e;

  function automatic logic [NumLanes-1:0] onehot8(input logic [SelW-1:0] idx);
    return {{(NumLanes-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/mux8_rr_scheduler_rr_pick8.sv
// Combinational round-robin picker: first requester after `last`, wrapping, `last` itself lowest.
module rr_pick8
  import mux8_rr_scheduler_pkg::*;
(
  input  logic [NumLanes-1:0] req,
  input  logic [SelW-1:0]     last,
  output logic [SelW-1:0]     idx,
  output logic                any
);

  logic [SelW-1:0] cand;

  // Scan from farthest to nearest so the nearest hit after `last` overwrites the rest.
  always_comb begin
    idx  = '0;
    cand = '0;
    for (int i = NumLanes; i > 0; i--) begin
      cand = last + SelW'(i);
      if (req[cand]) idx = cand;
    end
  end

  assign any = |req;

endmodule

// File: rtl/mux8_rr_scheduler.sv
// Round-robin burst scheduler sharing one registered valid/ready output slice between 8 lanes.
module mux8_rr_scheduler
  import mux8_rr_scheduler_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BURST = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NumLanes-1:0]       req,
  input  logic [NumLanes*WIDTH-1:0] in,
  input  logic                      out_ready,
  output logic [NumLanes-1:0]       grant,
  output logic [NumLanes-1:0]       ack,
  output logic [SelW-1:0]           select,
  output logic [WIDTH-1:0]          out,
  output logic                      out_valid,
  output logic [SelW-1:0]           out_owner
);

  localparam int unsigned CntW = $clog2(BURST) + 1;

  state_e              state_q;
  logic [NumLanes-1:0] grant_q;
  logic [SelW-1:0]     select_q;
  logic [SelW-1:0]     last_q;
  logic [CntW-1:0]     cnt_q;
  logic [WIDTH-1:0]    out_q;
  logic                out_valid_q;
  logic [SelW-1:0]     out_owner_q;

  logic [WIDTH-1:0] lanes [NumLanes];

  for (genvar g = 0; g < NumLanes; g++) begin : g_lanes
    assign lanes[g] = in[g*WIDTH +: WIDTH];
  end

  logic            load;
  logic            in_grant;
  logic            owner_req;
  logic            beat;
  logic            last_beat;
  logic            release_grant;
  logic [SelW-1:0] pick_base;
  logic [SelW-1:0] pick_idx;
  logic            pick_any;

  assign load          = !out_valid_q || out_ready;
  assign in_grant      = (state_q == StGrant);
  assign owner_req     = req[select_q];
  assign beat          = in_grant && owner_req && load;
  assign last_beat     = beat && (cnt_q == CntW'(BURST - 1));
  assign release_grant = in_grant && (last_beat || !owner_req);

  // Re-arbitrating from the current owner already ranks it last, so the owner only
  // wins again after a full burst when nobody else is requesting.
  assign pick_base = in_grant ? select_q : last_q;

  rr_pick8 u_pick (
    .req  (req),
    .last (pick_base),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      select_q    <= '0;
      last_q      <= SelW'(NumLanes - 1);
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_owner_q <= '0;
    end else begin
      if (beat) begin
        out_q       <= lanes[select_q];
        out_valid_q <= 1'b1;
        out_owner_q <= select_q;
        cnt_q       <= cnt_q + CntW'(1);
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (pick_any) begin
            grant_q  <= onehot8(pick_idx);
            select_q <= pick_idx;
            cnt_q    <= '0;
            state_q  <= StGrant;
          end
        end
        StGrant: begin
          if (release_grant) begin
            last_q <= select_q;
            cnt_q  <= '0;
            if (pick_any) begin
              grant_q  <= onehot8(pick_idx);
              select_q <= pick_idx;
            end else begin
              grant_q <= '0;
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign grant     = grant_q;
  assign ack       = grant_q & req & {NumLanes{load}};
  assign select    = select_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_owner = out_owner_q;

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Directed self-checking bench for mux8_rr_scheduler (BURST=4 main instance, BURST=1 side instance).
module tb_mux8_rr_scheduler;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  req;
  logic [7:0]  lane [8];
  logic [63:0] in_bus;
  logic        out_ready;

  logic [7:0] grant, ack, out;
  logic [2:0] select, out_owner;
  logic       out_valid;

  logic [7:0] grant1, ack1, out1;
  logic [2:0] select1, out_owner1;
  logic       out_valid1;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  always_comb begin
    in_bus = '0;
    for (int i = 0; i < 8; i++) in_bus[i*8 +: 8] = lane[i];
  end

  mux8_rr_scheduler #(.WIDTH(8), .BURST(4)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .in        (in_bus),
    .out_ready (out_ready),
    .grant     (grant),
    .ack       (ack),
    .select    (select),
    .out       (out),
    .out_valid (out_valid),
    .out_owner (out_owner)
  );

  mux8_rr_scheduler #(.WIDTH(8), .BURST(1)) dut1 (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .in        (in_bus),
    .out_ready (out_ready),
    .grant     (grant1),
    .ack       (ack1),
    .select    (select1),
    .out       (out1),
    .out_valid (out_valid1),
    .out_owner (out_owner1)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] oh(input int k);
    return 8'(1) << k;
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) lane[i] = 8'h30 + 8'(i);
    lane[2] = 8'hA5;

    // Reset state
    reset_n = 1'b0; req = 8'h00; out_ready = 1'b1;
    tick(); tick();
    check("rst_grant", grant, 8'h00);
    check("rst_select", 8'(select), 8'h00);
    check("rst_valid", 8'(out_valid), 8'h00);
    check("rst_out", out, 8'h00);
    check("rst_owner", 8'(out_owner), 8'h00);
    check("rst_ack", ack, 8'h00);
    check("rst_grant_b1", grant1, 8'h00);

    // Single requester on lane 2
    reset_n = 1'b1; req = 8'h04;
    tick();
    check("single_grant", grant, 8'h04);
    check("single_nobeat", 8'(out_valid), 8'h00);
    check("single_ack", ack, 8'h04);
    tick();
    check("single_out", out, 8'hA5);
    check("single_valid", 8'(out_valid), 8'h01);
    check("single_owner", 8'(out_owner), 8'h02);
    check("single_select", 8'(select), 8'h02);
    for (int n = 0; n < 8; n++) begin
      tick();
      check("single_stream_valid", 8'(out_valid), 8'h01);
      check("single_stream_grant", grant, 8'h04);
    end

    // Full contention: 4 beats per lane, 0..7 then 0, no bubbles
    reset_n = 1'b0; tick();
    reset_n = 1'b1; req = 8'hFF;
    tick();
    for (int n = 0; n < 33; n++) begin
      check("rr_grant", grant, oh((n / 4) % 8));
      check("rr_ack", ack, oh((n / 4) % 8));
      tick();
      check("rr_valid", 8'(out_valid), 8'h01);
      check("rr_owner", 8'(out_owner), 8'((n / 4) % 8));
      check("rr_data", out, lane[(n / 4) % 8]);
    end

    // Backpressure on lane 3, then reset while lane 4 is mid-burst
    lane[3] = 8'h33;
    reset_n = 1'b0; req = 8'h00; tick();
    reset_n = 1'b1; req = 8'h18;
    tick();
    check("bp_grant", grant, 8'h08);
    tick();
    check("bp_first_out", out, 8'h33);
    check("bp_first_owner", 8'(out_owner), 8'h03);
    out_ready = 1'b0; lane[3] = 8'h77;
    #1;
    check("bp_ack_stall", ack, 8'h00);
    for (int n = 0; n < 3; n++) begin
      tick();
      check("bp_hold_out", out, 8'h33);
      check("bp_hold_owner", 8'(out_owner), 8'h03);
      check("bp_hold_valid", 8'(out_valid), 8'h01);
      check("bp_hold_ack", ack, 8'h00);
      check("bp_hold_grant", grant, 8'h08);
    end
    out_ready = 1'b1;
    #1;
    check("bp_ack_resume", ack, 8'h08);
    tick();
    check("bp_beat2_out", out, 8'h77);
    tick();
    check("bp_beat3_grant", grant, 8'h08);
    tick();
    check("bp_beat4_switch", grant, 8'h10);
    check("bp_beat4_owner", 8'(out_owner), 8'h03);
    tick();
    check("bp_lane4_out", out, 8'h34);
    check("bp_lane4_owner", 8'(out_owner), 8'h04);
    check("bp_lane4_grant", grant, 8'h10);
    reset_n = 1'b0; req = 8'hFF;
    tick();
    check("mid_rst_grant", grant, 8'h00);
    check("mid_rst_valid", 8'(out_valid), 8'h00);
    check("mid_rst_out", out, 8'h00);
    check("mid_rst_owner", 8'(out_owner), 8'h00);
    check("mid_rst_select", 8'(select), 8'h00);
    reset_n = 1'b1;
    tick();
    check("mid_rst_regrant", grant, 8'h01);

    // Early drop: lane 5 drops after 2 beats while lane 1 requests
    reset_n = 1'b0; req = 8'h00; tick();
    reset_n = 1'b1; req = 8'h20;
    tick();
    check("drop_grant5", grant, 8'h20);
    tick(); tick();
    check("drop_owner5", 8'(out_owner), 8'h05);
    req = 8'h02;
    tick();
    check("drop_switch", grant, 8'h02);
    check("drop_select", 8'(select), 8'h01);
    check("drop_bubble", 8'(out_valid), 8'h00);
    tick();
    check("drop_owner1", 8'(out_owner), 8'h01);
    check("drop_valid1", 8'(out_valid), 8'h01);

    // Early drop to idle leaves last=5, so full contention resumes at lane 6
    reset_n = 1'b0; req = 8'h00; tick();
    reset_n = 1'b1; req = 8'h20;
    tick(); tick(); tick();
    req = 8'h00;
    tick();
    check("idle_grant", grant, 8'h00);
    check("idle_select_hold", 8'(select), 8'h05);
    req = 8'hFF;
    tick();
    check("after5_grant", grant, 8'h40);

    // BURST=1 alternates lanes 0 and 7 every beat
    reset_n = 1'b0; req = 8'h00; tick();
    reset_n = 1'b1; req = 8'h81;
    tick();
    for (int n = 0; n < 6; n++) begin
      check("b1_grant", grant1, (n % 2 == 0) ? 8'h01 : 8'h80);
      tick();
      check("b1_owner", 8'(out_owner1), (n % 2 == 0) ? 8'h00 : 8'h07);
      check("b1_valid", 8'(out_valid1), 8'h01);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux8_rr_scheduler.md
Name: mux8_rr_scheduler

Overview:
- Round-robin scheduler that shares one registered WIDTH-bit output channel between 8 requesters.
- Drives the 3-bit select of an internal registered 8:1 data mux.
- Grants one requester at a time for a burst of up to BURST beats.
- Presents the selected data on a valid/ready output register slice, so a downstream consumer can apply backpressure.

Parameters:
- WIDTH, 8, data width per requester lane.
- BURST, 4, maximum beats per grant before forced re-arbitration; legal range 1..16.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset_n  in  1  synchronous, active-low reset, sampled on posedge clock.
- req  in  8  per-requester request; req[i] high = lane i has a beat ready.
- in  in  8*WIDTH  packed lane data; lane i occupies in[(i+1)*WIDTH-1 : i*WIDTH].
- out_ready  in  1  downstream accepts out this cycle.
- grant  out  8  registered one-hot owner; all zero when idle.
- ack  out  8  combinational; ack[i] = grant[i] & req[i] & load, where load = !out_valid | out_ready. Lane i's beat is consumed at this edge, and the lane may advance its data.
- select  out  3  registered index of the current owner; holds its last value when idle.
- out  out  WIDTH  registered output data.
- out_valid  out  1  out holds an unconsumed beat.
- out_owner  out  3  lane index that produced the current out.

Behaviour:
- States: IDLE, GRANT. Internal registers: last[2:0] (last owner) and cnt (beats in the current grant, clog2(BURST)+1 bits).
- Reset (reset_n=0 at an edge):
  - state=IDLE, grant=0, select=0, last=7, cnt=0.
  - out=0, out_valid=0, out_owner=0.
  - Reset overrides every other event, including an in-flight burst or an unconsumed out.
- pick(r, p): first set bit of r scanning p+1, p+2, ... wrapping mod 8, ending at p. After reset, lane 0 has top priority.
- IDLE:
  - If |req: grant <= onehot(pick(req,last)), select <= pick index, cnt <= 0, state <= GRANT.
  - The first grant is visible 1 cycle after req rises. No beat is loaded in IDLE.
- GRANT, load cycle (req[select] & load):
  - out <= lane select, out_valid <= 1, out_owner <= select, cnt <= cnt+1.
- GRANT, release conditions:
  - (a) Load with cnt == BURST-1.
  - (b) req[select] == 0 at an edge.
  - On release, last <= select. If any other lane or the same lane still requests, re-arbitrate in the same edge with pick(req_next_mask, select): grant moves directly with no idle bubble, cnt <= 0.
  - req_next_mask = req, except that in case (a) the owner counts only if it is the sole requester (it wins last in rotation anyway).
  - If no request remains, grant <= 0 and state <= IDLE.
- out_valid falls when out_ready=1 and there is no load at that edge. While out_valid=1 and out_ready=0, out, out_valid and out_owner hold, and ack=0 for all lanes.
- Throughput: 1 beat per cycle while out_ready=1, including across grant switches.
- Grant switch latency: 0 cycles after a release edge. Data latency: a beat acked at edge t appears on out after edge t.
- grant is always one-hot or zero. ack has at most one bit set.
- BURST=1: rotates after every beat.

Decomposition:
- Shared package: state encoding (IDLE, GRANT), lane count constant (8), select width (3).
- One sub-module, rr_pick8: combinational round-robin picker with inputs req[7:0] and last[2:0], outputs idx[2:0] and any.

Test Plan:
- Reset then single requester: req=8'h04, out_ready=1, lane2 data 8'hA5.
  - grant=8'h04 one cycle later.
  - out=8'hA5 with out_valid=1 the following cycle.
  - Beats continue; a rotation back to lane 2 every 4 beats.
- All 8 request continuously, BURST=4, out_ready=1:
  - grant order 0,1,...,7,0.
  - Exactly 4 consecutive beats per lane.
  - No bubble in out_valid.
- Backpressure: lane 3 granted, out_ready=0 for 3 cycles after the first beat.
  - out, out_owner=3, out_valid hold; ack=0.
  - On release of backpressure, the beat count resumes at 2.
- Early drop: lane 5 drops req after 2 beats while lane 1 requests.
  - grant moves to lane 1 at the same edge; last=5.
  - Next full-contention arbitration starts at lane 6.
- Reset mid-burst: assert reset_n=0 while out_valid=1 and grant=8'h10.
  - Next edge: grant=0, out_valid=0, out=0, state IDLE.
  - After release, lane 0 wins if all lanes request.
- BURST=1 with req=8'h81:
  - grants alternate lane 0, lane 7 every cycle.
  - out_owner alternates 0,7.
